ram_program_loader: RTL and testbench



---
 rtl/ram_program_loader.sv | 160 ++++++++++++++++
 tb/tb_ram_program_loader.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_program_loader.sv
// Bus-side program loader: streams bytes into the CPU RAM through the MAR/RAM
// strobes while holding the CPU core in reset.
module ram_program_loader #(
   parameter  int unsigned RAM_BYTES = 16,
   localparam int unsigned ADDR_W    = $clog2(RAM_BYTES),
   localparam int unsigned CNT_W     = $clog2(RAM_BYTES + 1),
   localparam int unsigned DATA_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   output logic              n_load_addr,
   output logic              n_load_data,
   output logic              n_write,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  byte_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ADDR,
      S_DATA,
      S_WRITE,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                last_q, last_d;
   logic [CNT_W-1:0]    count_d;

   logic                in_ready_d;
   logic [DATA_W-1:0]   bus_out_d;
   logic                bus_oe_d;
   logic                n_load_addr_d;
   logic                n_load_data_d;
   logic                n_write_d;
   logic                busy_d;
   logic                done_d;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         last_q     <= 1'b0;
         byte_count <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         last_q     <= last_d;
         byte_count <= count_d;
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      last_d  = last_q;
      count_d = byte_count;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WAIT;
               addr_d  = '0;
               count_d = '0;
            end
         end
         S_WAIT: begin
            if (in_valid && in_ready) begin
               data_d  = in_data;
               last_d  = in_last;
               state_d = S_ADDR;
            end
         end
         S_ADDR:  state_d = S_DATA;
         S_DATA:  state_d = S_WRITE;
         S_WRITE: begin
            count_d = byte_count + CNT_W'(1);
            // The last RAM location ends the load; the address never wraps.
            if (last_q || (addr_q == ADDR_W'(RAM_BYTES - 1))) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = S_WAIT;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the next state, so every output is a flop
   always_comb begin
      in_ready_d    = 1'b0;
      bus_out_d     = '0;
      bus_oe_d      = 1'b0;
      n_load_addr_d = 1'b1;
      n_load_data_d = 1'b1;
      n_write_d     = 1'b1;
      busy_d        = (state_d != S_IDLE);
      done_d        = 1'b0;
      case (state_d)
         S_WAIT:  in_ready_d = 1'b1;
         S_ADDR: begin
            bus_oe_d      = 1'b1;
            bus_out_d     = DATA_W'(addr_d);
            n_load_addr_d = 1'b0;
         end
         S_DATA: begin
            bus_oe_d      = 1'b1;
            bus_out_d     = data_d;
            n_load_data_d = 1'b0;
         end
         S_WRITE: n_write_d = 1'b0;
         S_DONE:  done_d    = 1'b1;
         default: ;
      endcase
   end

   // Registered outputs; reset releases the bus and the core immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready    <= 1'b0;
         bus_out     <= '0;
         bus_oe      <= 1'b0;
         n_load_addr <= 1'b1;
         n_load_data <= 1'b1;
         n_write     <= 1'b1;
         cpu_hold    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         in_ready    <= in_ready_d;
         bus_out     <= bus_out_d;
         bus_oe      <= bus_oe_d;
         n_load_addr <= n_load_addr_d;
         n_load_data <= n_load_data_d;
         n_write     <= n_write_d;
         cpu_hold    <= busy_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

endmodule

// File: tb/tb_ram_program_loader.sv
// Directed bench for ram_program_loader with a MAR/RAM model on the bus side.
module tb_ram_program_loader;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [7:0] bus_out;
   logic       bus_oe;
   logic       n_load_addr;
   logic       n_load_data;
   logic       n_write;
   logic       cpu_hold;
   logic       busy;
   logic       done;
   logic [4:0] byte_count;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [3:0] mar;
   logic [7:0] mdr;
   logic [7:0] ram [16];
   int         wr_cnt [16];
   int         wr_q [$];

   ram_program_loader dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .bus_out(bus_out), .bus_oe(bus_oe), .n_load_addr(n_load_addr),
      .n_load_data(n_load_data), .n_write(n_write), .cpu_hold(cpu_hold),
      .busy(busy), .done(done), .byte_count(byte_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cyc holds the index of the most recent rising edge
   always @(posedge clk) cyc++;

   // Downstream MAR/RAM path, loading only from a driven bus
   always @(posedge clk) begin
      if (!n_load_addr && bus_oe) mar = bus_out[3:0];
      if (!n_load_data && bus_oe) mdr = bus_out;
      if (!n_write) begin
         ram[mar] = mdr;
         wr_cnt[mar] = wr_cnt[mar] + 1;
         wr_q.push_back(int'(mar));
      end
   end

   // Bus invariants: one strobe at most, quiet bus when not driving
   always @(negedge clk) begin
      n_tests++;
      if ((32'(!n_load_addr) + 32'(!n_load_data) + 32'(!n_write)) > 1) begin
         n_fail++;
         $display("FAIL strobe_overlap: got a=%b d=%b w=%b, required at most one low",
                  n_load_addr, n_load_data, n_write);
      end
      n_tests++;
      if (!bus_oe && bus_out !== 8'h00) begin
         n_fail++;
         $display("FAIL bus_idle_zero: got %h, required 00", bus_out);
      end
   end

   task automatic clear_model();
      for (int i = 0; i < 16; i++) wr_cnt[i] = 0;
      wr_q.delete();
   endtask

   // Presents one byte and returns at the negedge after the accepting edge
   task automatic send_byte(input logic [7:0] d, input logic l, output int acc);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int i = 0; i < 200 && in_ready !== 1'b1; i++) @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=%b, required 1", in_ready);
      end
      @(negedge clk);
      acc      = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(output int dc);
      for (int i = 0; i < 300 && done !== 1'b1; i++) @(negedge clk);
      dc = cyc;
      n_tests++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL done_timeout: got done=%b, required 1", done);
      end
   endtask

   task automatic begin_load(output int e0);
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e0 = cyc;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_tests++;
      if ({n_load_addr, n_load_data, n_write} !== 3'b111 || bus_oe !== 1'b0 ||
          bus_out !== 8'h00 || in_ready !== 1'b0 || busy !== 1'b0 ||
          cpu_hold !== 1'b0 || done !== 1'b0 || byte_count !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_values: got strb=%b oe=%b bus=%h rdy=%b busy=%b hold=%b done=%b cnt=%0d, required 111/0/00/0/0/0/0/0",
                  {n_load_addr, n_load_data, n_write}, bus_oe, bus_out, in_ready,
                  busy, cpu_hold, done, byte_count);
      end
      rst = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h33;
      in_last  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++;
      if (n_load_addr !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pre_addr: got n_load_addr=%b, required 0", n_load_addr);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (n_load_addr !== 1'b1 || bus_oe !== 1'b0 || cpu_hold !== 1'b0 || bus_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_async: got n_load_addr=%b oe=%b hold=%b bus=%h, required 1/0/0/00",
                  n_load_addr, bus_oe, cpu_hold, bus_out);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || n_write !== 1'b1 || byte_count !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_release: got rdy=%b busy=%b n_write=%b cnt=%0d, required 0/0/1/0",
                  in_ready, busy, n_write, byte_count);
      end
   endtask

   task automatic test_single();
      int e0, ea, dc;
      clear_model();
      begin_load(e0);
      n_tests++;
      if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL single_wait: got rdy=%b hold=%b, required 1/1", in_ready, cpu_hold);
      end
      send_byte(8'h5A, 1'b1, ea);
      n_tests++;
      if (ea != e0 + 1 || n_load_addr !== 1'b0 || bus_oe !== 1'b1 || bus_out !== 8'h00) begin
         n_fail++;
         $display("FAIL single_addr: got edge=%0d a=%b oe=%b bus=%h, required %0d/0/1/00",
                  ea, n_load_addr, bus_oe, bus_out, e0 + 1);
      end
      @(negedge clk);
      n_tests++;
      if (n_load_data !== 1'b0 || bus_oe !== 1'b1 || bus_out !== 8'h5A) begin
         n_fail++;
         $display("FAIL single_data: got d=%b oe=%b bus=%h, required 0/1/5a",
                  n_load_data, bus_oe, bus_out);
      end
      @(negedge clk);
      n_tests++;
      if (n_write !== 1'b0 || bus_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL single_write: got w=%b oe=%b, required 0/0", n_write, bus_oe);
      end
      wait_done(dc);
      n_tests++;
      if (dc != ea + 3 || busy !== 1'b1 || byte_count !== 5'd1) begin
         n_fail++;
         $display("FAIL single_done: got edge=%0d busy=%b cnt=%0d, required %0d/1/1",
                  dc, busy, byte_count, ea + 3);
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || byte_count !== 5'd1 ||
          wr_q.size() != 1 || wr_cnt[0] != 1 || ram[0] !== 8'h5A) begin
         n_fail++;
         $display("FAIL single_after: got busy=%b done=%b cnt=%0d writes=%0d ram0=%h, required 0/0/1/1/5a",
                  busy, done, byte_count, wr_q.size(), ram[0]);
      end
   endtask

   task automatic test_full();
      int e0, ea, dc;
      clear_model();
      begin_load(e0);
      for (int k = 0; k < 16; k++) send_byte(8'(16 + k), 1'b0, ea);
      wait_done(dc);
      n_tests++;
      if (dc != e0 + 64 || byte_count !== 5'd16 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_done: got edge=%0d cnt=%0d rdy=%b, required %0d/16/0",
                  dc, byte_count, in_ready, e0 + 64);
      end
      in_valid = 1'b1;
      in_data  = 8'hEE;
      @(negedge clk);
      n_tests++;
      if (cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_release: got hold=%b rdy=%b, required 0/0", cpu_hold, in_ready);
      end
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      n_tests++;
      if (wr_q.size() != 16 || byte_count !== 5'd16) begin
         n_fail++;
         $display("FAIL full_count: got writes=%0d cnt=%0d, required 16/16", wr_q.size(), byte_count);
      end
      for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
         n_tests++;
         if (wr_q[i] != i || ram[i] !== 8'(16 + i)) begin
            n_fail++;
            $display("FAIL full_order[%0d]: got addr=%0d data=%h, required %0d/%h",
                     i, wr_q[i], ram[i], i, 8'(16 + i));
         end
      end
   endtask

   task automatic test_back_to_back_gaps();
      int e0, ea, dc;
      logic [7:0] vals [3];
      vals[0] = 8'hA1;
      vals[1] = 8'hB2;
      vals[2] = 8'hC3;
      clear_model();
      begin_load(e0);
      for (int k = 0; k < 3; k++) begin
         send_byte(vals[k], (k == 2), ea);
         if (k < 2) begin
            repeat (3) @(negedge clk);
            repeat (5) begin
               n_tests++;
               if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                  n_fail++;
                  $display("FAIL gap_wait: got rdy=%b busy=%b done=%b, required 1/1/0",
                           in_ready, busy, done);
               end
               @(negedge clk);
            end
         end
      end
      wait_done(dc);
      n_tests++;
      if (dc != ea + 3 || byte_count !== 5'd3) begin
         n_fail++;
         $display("FAIL gap_done: got edge=%0d cnt=%0d, required %0d/3", dc, byte_count, ea + 3);
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (wr_cnt[i] != 1 || ram[i] !== vals[i]) begin
            n_fail++;
            $display("FAIL gap_write[%0d]: got count=%0d data=%h, required 1/%h",
                     i, wr_cnt[i], ram[i], vals[i]);
         end
      end
   endtask

   task automatic test_ignored_start();
      int e0, ea, dc;
      clear_model();
      begin_load(e0);
      for (int k = 0; k < 3; k++) send_byte(8'(8'h40 + k), 1'b0, ea);
      @(negedge clk);
      n_tests++;
      if (n_load_data !== 1'b0 || bus_out !== 8'h42) begin
         n_fail++;
         $display("FAIL ign_data: got d=%b bus=%h, required 0/42", n_load_data, bus_out);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_tests++;
      if (n_write !== 1'b0 || busy !== 1'b1 || byte_count !== 5'd2) begin
         n_fail++;
         $display("FAIL ign_write: got w=%b busy=%b cnt=%0d, required 0/1/2",
                  n_write, busy, byte_count);
      end
      send_byte(8'h43, 1'b1, ea);
      n_tests++;
      if (n_load_addr !== 1'b0 || bus_out !== 8'h03) begin
         n_fail++;
         $display("FAIL ign_addr: got a=%b bus=%h, required 0/03", n_load_addr, bus_out);
      end
      wait_done(dc);
      repeat (3) @(negedge clk);
      n_tests++;
      if (byte_count !== 5'd4 || wr_q.size() != 4 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ign_count: got cnt=%0d writes=%0d busy=%b, required 4/4/0",
                  byte_count, wr_q.size(), busy);
      end
      for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
         n_tests++;
         if (wr_q[i] != i || ram[i] !== 8'(8'h40 + i)) begin
            n_fail++;
            $display("FAIL ign_order[%0d]: got addr=%0d data=%h, required %0d/%h",
                     i, wr_q[i], ram[i], i, 8'(8'h40 + i));
         end
      end
   endtask

   task automatic test_reset_mid_load();
      int e0, ea, dc;
      clear_model();
      begin_load(e0);
      for (int k = 0; k < 4; k++) send_byte(8'(8'hD0 + k), 1'b0, ea);
      repeat (2) @(negedge clk);
      n_tests++;
      if (n_write !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_pre_write: got n_write=%b, required 0", n_write);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (n_write !== 1'b1 || bus_oe !== 1'b0 || cpu_hold !== 1'b0 || byte_count !== 5'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got w=%b oe=%b hold=%b cnt=%0d, required 1/0/0/0",
                  n_write, bus_oe, cpu_hold, byte_count);
      end
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if (wr_q.size() != 3 || wr_cnt[3] != 0) begin
         n_fail++;
         $display("FAIL mid_abort: got writes=%0d addr3=%0d, required 3/0", wr_q.size(), wr_cnt[3]);
      end
      clear_model();
      begin_load(e0);
      send_byte(8'hC0, 1'b0, ea);
      send_byte(8'hC1, 1'b1, ea);
      wait_done(dc);
      n_tests++;
      if (byte_count !== 5'd2 || wr_q.size() != 2 || ram[0] !== 8'hC0 || ram[1] !== 8'hC1) begin
         n_fail++;
         $display("FAIL mid_reload: got cnt=%0d writes=%0d ram0=%h ram1=%h, required 2/2/c0/c1",
                  byte_count, wr_q.size(), ram[0], ram[1]);
      end
      n_tests++;
      if (wr_q.size() == 2 && (wr_q[0] != 0 || wr_q[1] != 1)) begin
         n_fail++;
         $display("FAIL mid_order: got %0d,%0d, required 0,1", wr_q[0], wr_q[1]);
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      in_last  = 1'b0;
      clear_model();
      test_reset();
      test_single();
      test_full();
      test_back_to_back_gaps();
      test_ignored_start();
      test_reset_mid_load();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
